// File: rtl/shader_affine_pipe_pkg.sv
// -----------------------------------------------------------------------------
// shader_pkg
// Shared types and constants for the affine texture-coordinate pipeline.
//   coord_t    : unsigned screen/texture coordinate
//   mat_elem_t : signed fixed-point matrix element (F fraction bits)
//   mat_t      : 2x2 matrix held as {a, b, c, d}
//   MAT_ONE    : fixed-point 1.0
//   WRAP_CLAMP / WRAP_MOD : out-of-range policy selectors
// -----------------------------------------------------------------------------
package shader_pkg;

    localparam int W_DEF  = 12;
    localparam int MW_DEF = 16;
    localparam int F_DEF  = 8;

    localparam int WRAP_CLAMP = 0;
    localparam int WRAP_MOD   = 1;

    typedef logic unsigned [W_DEF-1:0] coord_t;
    typedef logic signed [MW_DEF-1:0]  mat_elem_t;
    typedef mat_elem_t                 mat_t [4];

    localparam mat_elem_t MAT_ONE = mat_elem_t'(1 << F_DEF);

endpackage

// File: rtl/shader_affine_sat.sv
// -----------------------------------------------------------------------------
// shader_affine_sat
// Combinational range reduction of a signed intermediate coordinate onto the
// unsigned W-bit texture space, flagging values outside [0, 2^W-1].
//   x   : signed input, IN_W bits
//   y   : clamped (WRAP=WRAP_CLAMP) or modulo-2^W (WRAP=WRAP_MOD) result
//   oob : x was negative or above 2^W-1
// -----------------------------------------------------------------------------
module shader_affine_sat
    import shader_pkg::*;
#(
    parameter int IN_W = 31,
    parameter int W    = 12,
    parameter int WRAP = WRAP_CLAMP
) (
    input  logic signed [IN_W-1:0] x,
    output logic        [W-1:0]    y,
    output logic                   oob
);

    // Returns {out_of_range, reduced_value}.
    function automatic logic [W:0] clamp_wrap(input logic signed [IN_W-1:0] val);
        logic         neg;
        logic         over;
        logic [W-1:0] res;
        neg  = val[IN_W-1];
        // Non-negative but with any bit set above the W-bit field.
        over = ~neg & (|val[IN_W-2:W]);
        if ((WRAP == WRAP_MOD) || !(neg | over)) begin
            res = val[W-1:0];
        end else if (neg) begin
            res = '0;
        end else begin
            res = '1;
        end
        return {neg | over, res};
    endfunction

    always_comb begin
        {oob, y} = clamp_wrap(x);
    end

endmodule

// File: rtl/shader_affine_pipe.sv
// -----------------------------------------------------------------------------
// shader_affine_pipe
// Three-stage pipelined affine map from screen pixel (px,py) to texture
// coordinate (tu,tv):
//   u = ((a*dx + b*dy) >>> F) + qx0,  v = ((c*dx + d*dy) >>> F) + qy0
//   with dx = px - qx, dy = py - qy.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   cfg_wen / cfg_ready    : config load request / pipe empty and loadable
//   qx, qy, qx0, qy0, qm   : square position, texture origin, matrix {a,b,c,d}
//   s_valid/s_ready/px/py  : pixel input handshake
//   m_valid/m_ready/tu/tv/oob : result output handshake, oob = pre-range overflow
// -----------------------------------------------------------------------------
module shader_affine_pipe
    import shader_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int MW   = MW_DEF,
    parameter int F    = F_DEF,
    parameter int WRAP = WRAP_CLAMP
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cfg_wen,
    output logic               cfg_ready,
    input  logic [W-1:0]       qx,
    input  logic [W-1:0]       qy,
    input  logic [W-1:0]       qx0,
    input  logic [W-1:0]       qy0,
    input  logic [3:0][MW-1:0] qm,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W-1:0]       px,
    input  logic [W-1:0]       py,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       tu,
    output logic [W-1:0]       tv,
    output logic               oob
);

    localparam int DW = W + 1;      // signed pixel-to-square difference
    localparam int PW = MW + W + 1; // full-precision product
    localparam int SW = PW + 1;     // sum of two products
    localparam int OW = SW + 1;     // after origin offset

    logic en;
    logic accept;
    logic cfg_load;

    logic [W-1:0]         cfg_qx_q, cfg_qx_d, cfg_qy_q, cfg_qy_d;
    logic [W-1:0]         cfg_qx0_q, cfg_qx0_d, cfg_qy0_q, cfg_qy0_d;
    logic signed [MW-1:0] cfg_m_q [4];
    logic signed [MW-1:0] cfg_m_d [4];

    logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;

    logic signed [DW-1:0] dx_p1_q, dx_p1_d, dy_p1_q, dy_p1_d;
    logic signed [PW-1:0] prod_p2_q [4];
    logic signed [PW-1:0] prod_p2_d [4];

    logic signed [SW-1:0] sum_u, sum_v;
    logic signed [OW-1:0] u_full, v_full;
    logic [W-1:0]         sat_tu, sat_tv;
    logic                 sat_oob_u, sat_oob_v;

    logic [W-1:0] tu_p3_q, tu_p3_d, tv_p3_q, tv_p3_d;
    logic         oob_p3_q, oob_p3_d;

    // Flow control: the whole pipe advances as one; a config request
    // blocks new pixels so the load can never coincide with an accept.
    always_comb begin
        en        = ~vld_p3_q | m_ready;
        s_ready   = en & ~cfg_wen;
        accept    = s_valid & s_ready;
        cfg_ready = ~(vld_p1_q | vld_p2_q | vld_p3_q);
        cfg_load  = cfg_wen & cfg_ready;
    end

    // S3 arithmetic ahead of the range unit.
    always_comb begin
        sum_u  = SW'(prod_p2_q[0]) + SW'(prod_p2_q[1]);
        sum_v  = SW'(prod_p2_q[2]) + SW'(prod_p2_q[3]);
        u_full = OW'(sum_u >>> F) + OW'($signed({1'b0, cfg_qx0_q}));
        v_full = OW'(sum_v >>> F) + OW'($signed({1'b0, cfg_qy0_q}));
    end

    shader_affine_sat #(.IN_W(OW), .W(W), .WRAP(WRAP)) u_sat_u (
        .x   (u_full),
        .y   (sat_tu),
        .oob (sat_oob_u)
    );

    shader_affine_sat #(.IN_W(OW), .W(W), .WRAP(WRAP)) u_sat_v (
        .x   (v_full),
        .y   (sat_tv),
        .oob (sat_oob_v)
    );

    always_comb begin
        cfg_qx_d  = cfg_qx_q;
        cfg_qy_d  = cfg_qy_q;
        cfg_qx0_d = cfg_qx0_q;
        cfg_qy0_d = cfg_qy0_q;
        cfg_m_d   = cfg_m_q;
        if (cfg_load) begin
            cfg_qx_d   = qx;
            cfg_qy_d   = qy;
            cfg_qx0_d  = qx0;
            cfg_qy0_d  = qy0;
            cfg_m_d[0] = $signed(qm[3]);
            cfg_m_d[1] = $signed(qm[2]);
            cfg_m_d[2] = $signed(qm[1]);
            cfg_m_d[3] = $signed(qm[0]);
        end

        vld_p1_d = vld_p1_q;
        vld_p2_d = vld_p2_q;
        vld_p3_d = vld_p3_q;
        if (en) begin
            vld_p1_d = accept;
            vld_p2_d = vld_p1_q;
            vld_p3_d = vld_p2_q;
        end

        // ---- S1: pixel minus square position ----
        dx_p1_d = dx_p1_q;
        dy_p1_d = dy_p1_q;
        if (accept) begin
            dx_p1_d = $signed({1'b0, px}) - $signed({1'b0, cfg_qx_q});
            dy_p1_d = $signed({1'b0, py}) - $signed({1'b0, cfg_qy_q});
        end

        // ---- S2: four matrix products ----
        prod_p2_d = prod_p2_q;
        if (en && vld_p1_q) begin
            prod_p2_d[0] = PW'(cfg_m_q[0]) * PW'(dx_p1_q);
            prod_p2_d[1] = PW'(cfg_m_q[1]) * PW'(dy_p1_q);
            prod_p2_d[2] = PW'(cfg_m_q[2]) * PW'(dx_p1_q);
            prod_p2_d[3] = PW'(cfg_m_q[3]) * PW'(dy_p1_q);
        end

        // ---- S3: sum, shift, offset, range-reduce ----
        tu_p3_d  = tu_p3_q;
        tv_p3_d  = tv_p3_q;
        oob_p3_d = oob_p3_q;
        if (en && vld_p2_q) begin
            tu_p3_d  = sat_tu;
            tv_p3_d  = sat_tv;
            oob_p3_d = sat_oob_u | sat_oob_v;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_qx_q  <= '0;
            cfg_qy_q  <= '0;
            cfg_qx0_q <= '0;
            cfg_qy0_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cfg_m_q[i] <= '0;
            end
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            tu_p3_q  <= '0;
            tv_p3_q  <= '0;
            oob_p3_q <= 1'b0;
        end else begin
            cfg_qx_q  <= cfg_qx_d;
            cfg_qy_q  <= cfg_qy_d;
            cfg_qx0_q <= cfg_qx0_d;
            cfg_qy0_q <= cfg_qy0_d;
            cfg_m_q   <= cfg_m_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            tu_p3_q   <= tu_p3_d;
            tv_p3_q   <= tv_p3_d;
            oob_p3_q  <= oob_p3_d;
        end
    end

    // Intermediate datapath carries no reset; its contents are only
    // observed when the matching stage valid is set.
    always_ff @(posedge aclk) begin
        dx_p1_q   <= dx_p1_d;
        dy_p1_q   <= dy_p1_d;
        prod_p2_q <= prod_p2_d;
    end

    assign m_valid = vld_p3_q;
    assign tu      = tu_p3_q;
    assign tv      = tv_p3_q;
    assign oob     = oob_p3_q;

endmodule

// File: tb/tb_shader_affine_pipe.sv
// -----------------------------------------------------------------------------
// tb_shader_affine_pipe
// Drives a clamp instance and a wrap instance of shader_affine_pipe with the
// same stimulus and checks both against an integer reference model.
// -----------------------------------------------------------------------------
module tb_shader_affine_pipe;
    import shader_pkg::*;

    typedef struct packed {
        logic [11:0] tu;
        logic [11:0] tv;
        logic        oob;
    } res_t;

    logic             aclk;
    logic             aresetn;
    logic             cfg_wen;
    logic             cfg_ready_c, cfg_ready_w;
    logic [11:0]      qx, qy, qx0, qy0;
    logic [3:0][15:0] qm;
    logic             s_valid;
    logic             s_ready_c, s_ready_w;
    logic [11:0]      px, py;
    logic             m_valid_c, m_valid_w;
    logic             m_ready;
    logic [11:0]      tu_c, tv_c, tu_w, tv_w;
    logic             oob_c, oob_w;

    int n_checks = 0;
    int n_pass   = 0;

    // Shadow of the configuration the DUTs hold.
    int ca, cb, cc, cd, cqx, cqy, cqx0, cqy0;

    shader_affine_pipe #(.W(12), .MW(16), .F(8), .WRAP(0)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .cfg_wen(cfg_wen), .cfg_ready(cfg_ready_c),
        .qx(qx), .qy(qy), .qx0(qx0), .qy0(qy0), .qm(qm),
        .s_valid(s_valid), .s_ready(s_ready_c), .px(px), .py(py),
        .m_valid(m_valid_c), .m_ready(m_ready), .tu(tu_c), .tv(tv_c), .oob(oob_c)
    );

    shader_affine_pipe #(.W(12), .MW(16), .F(8), .WRAP(1)) dut_w (
        .aclk(aclk), .aresetn(aresetn), .cfg_wen(cfg_wen), .cfg_ready(cfg_ready_w),
        .qx(qx), .qy(qy), .qx0(qx0), .qy0(qy0), .qm(qm),
        .s_valid(s_valid), .s_ready(s_ready_w), .px(px), .py(py),
        .m_valid(m_valid_w), .m_ready(m_ready), .tu(tu_w), .tv(tv_w), .oob(oob_w)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // floor(n / 256)
    function automatic longint fdiv(input longint n);
        if (n >= 0) return n / 256;
        return -((-n + 255) / 256);
    endfunction

    function automatic res_t model(input int x, input int y, input bit wrap);
        longint dx, dy, u, v;
        res_t   r;
        dx = longint'(x - cqx);
        dy = longint'(y - cqy);
        u  = fdiv(ca * dx + cb * dy) + cqx0;
        v  = fdiv(cc * dx + cd * dy) + cqy0;
        r.oob = (u < 0) || (u > 4095) || (v < 0) || (v > 4095);
        if (wrap) begin
            r.tu = 12'(((u % 4096) + 4096) % 4096);
            r.tv = 12'(((v % 4096) + 4096) % 4096);
        end else begin
            r.tu = 12'((u < 0) ? 0 : ((u > 4095) ? 4095 : u));
            r.tv = 12'((v < 0) ? 0 : ((v > 4095) ? 4095 : v));
        end
        return r;
    endfunction

    task automatic load_cfg(input int a, input int b, input int c, input int d,
                            input int x, input int y, input int x0, input int y0);
        int n;
        @(negedge aclk);
        s_valid = 1'b0;
        qm      = {16'(a), 16'(b), 16'(c), 16'(d)};
        qx = 12'(x); qy = 12'(y); qx0 = 12'(x0); qy0 = 12'(y0);
        cfg_wen = 1'b1;
        #1;
        n = 0;
        while (!cfg_ready_c && n < 200) begin
            @(negedge aclk); #1; n++;
        end
        if (n >= 200) begin
            n_checks++;
            $display("FAIL cfg_load_timeout cfg_ready=%0b want 1", cfg_ready_c);
        end
        @(negedge aclk);
        cfg_wen = 1'b0;
        ca = a; cb = b; cc = c; cd = d; cqx = x; cqy = y; cqx0 = x0; cqy0 = y0;
    endtask

    // Sends one pixel into an empty pipe, returns latency and both results.
    task automatic send_one(input int x, input int y, output int cyc,
                            output res_t rc, output res_t rw);
        @(negedge aclk);
        m_ready = 1'b1;
        s_valid = 1'b1;
        px = 12'(x); py = 12'(y);
        @(negedge aclk);
        s_valid = 1'b0;
        cyc = 1;
        while (!m_valid_c && cyc < 20) begin
            @(negedge aclk); cyc++;
        end
        rc = '{tu_c, tv_c, oob_c};
        rw = '{tu_w, tv_w, oob_w};
        @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0; cfg_wen = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        qx = '0; qy = '0; qx0 = '0; qy0 = '0; qm = '0; px = '0; py = '0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk); #1;
        n_checks++; if (m_valid_c !== 1'b0) $display("FAIL reset_m_valid got %0b want 0", m_valid_c); else n_pass++;
        n_checks++; if ({tu_c, tv_c, oob_c} !== 25'd0) $display("FAIL reset_out got %0d/%0d/%0b want 0/0/0", tu_c, tv_c, oob_c); else n_pass++;
        n_checks++; if (cfg_ready_c !== 1'b1) $display("FAIL reset_cfg_ready got %0b want 1", cfg_ready_c); else n_pass++;
        n_checks++; if (s_ready_c !== 1'b1) $display("FAIL reset_s_ready got %0b want 1", s_ready_c); else n_pass++;
        n_checks++; if ({m_valid_w, tu_w, tv_w, oob_w} !== 26'd0) $display("FAIL reset_wrap_out got %0b/%0d/%0d want all 0", m_valid_w, tu_w, tv_w); else n_pass++;
    endtask

    task automatic test_identity();
        int lat; res_t rc, rw;
        load_cfg(MAT_ONE, 0, 0, MAT_ONE, 100, 50, 10, 20);
        send_one(150, 60, lat, rc, rw);
        n_checks++; if (lat !== 3) $display("FAIL identity_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (rc !== res_t'({12'd60, 12'd30, 1'b0})) $display("FAIL identity_clamp got %0d,%0d,%0b want 60,30,0", rc.tu, rc.tv, rc.oob); else n_pass++;
        n_checks++; if (rw !== res_t'({12'd60, 12'd30, 1'b0})) $display("FAIL identity_wrap got %0d,%0d,%0b want 60,30,0", rw.tu, rw.tv, rw.oob); else n_pass++;
    endtask

    task automatic test_rotation();
        int lat; res_t rc, rw;
        load_cfg(0, -256, 256, 0, 200, 200, 10, 20);
        send_one(205, 203, lat, rc, rw);
        n_checks++; if (rc !== res_t'({12'd7, 12'd25, 1'b0})) $display("FAIL rotation got %0d,%0d,%0b want 7,25,0", rc.tu, rc.tv, rc.oob); else n_pass++;
        n_checks++; if (rw !== res_t'({12'd7, 12'd25, 1'b0})) $display("FAIL rotation_wrap got %0d,%0d,%0b want 7,25,0", rw.tu, rw.tv, rw.oob); else n_pass++;
    endtask

    task automatic test_range();
        int lat; res_t rc, rw;
        load_cfg(512, 0, 0, 512, 0, 0, 0, 0);
        send_one(4000, 4000, lat, rc, rw);
        n_checks++; if (rc !== res_t'({12'd4095, 12'd4095, 1'b1})) $display("FAIL overflow_clamp got %0d,%0d,%0b want 4095,4095,1", rc.tu, rc.tv, rc.oob); else n_pass++;
        n_checks++; if (rw !== res_t'({12'd3904, 12'd3904, 1'b1})) $display("FAIL overflow_wrap got %0d,%0d,%0b want 3904,3904,1", rw.tu, rw.tv, rw.oob); else n_pass++;
        load_cfg(512, 0, 0, 512, 100, 0, 0, 0);
        send_one(0, 0, lat, rc, rw);
        n_checks++; if (rc !== res_t'({12'd0, 12'd0, 1'b1})) $display("FAIL underflow_clamp got %0d,%0d,%0b want 0,0,1", rc.tu, rc.tv, rc.oob); else n_pass++;
        n_checks++; if (rw !== res_t'({12'd3896, 12'd0, 1'b1})) $display("FAIL underflow_wrap got %0d,%0d,%0b want 3896,0,1", rw.tu, rw.tv, rw.oob); else n_pass++;
        // Exactly at the top edge is still in range.
        load_cfg(MAT_ONE, 0, 0, MAT_ONE, 0, 0, 0, 0);
        send_one(4095, 0, lat, rc, rw);
        n_checks++; if (rc !== res_t'({12'd4095, 12'd0, 1'b0})) $display("FAIL edge_4095 got %0d,%0d,%0b want 4095,0,0", rc.tu, rc.tv, rc.oob); else n_pass++;
    endtask

    task automatic test_backpressure();
        int   sent, rcv;
        bit   stall_prev;
        res_t prev;
        load_cfg(MAT_ONE, 0, 0, MAT_ONE, 0, 0, 0, 0);
        sent = 0; rcv = 0; stall_prev = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            @(negedge aclk);
            if (stall_prev) begin
                n_checks++;
                if ({m_valid_c, tu_c, tv_c, oob_c} !== {1'b1, prev})
                    $display("FAIL bp_hold got %0b,%0d,%0d want 1,%0d,%0d", m_valid_c, tu_c, tv_c, prev.tu, prev.tv);
                else n_pass++;
            end
            m_ready = !(cyc >= 4 && cyc <= 9);
            s_valid = (sent < 8);
            px = 12'(sent); py = '0;
            #1;
            if (m_valid_c && !m_ready) begin
                n_checks++; if (s_ready_c !== 1'b0) $display("FAIL bp_s_ready got %0b want 0", s_ready_c); else n_pass++;
            end
            if (m_valid_c && m_ready) begin
                n_checks++;
                if ({tu_c, tv_c, oob_c, tu_w} !== {12'(rcv), 12'd0, 1'b0, 12'(rcv)})
                    $display("FAIL bp_order got %0d,%0d,%0b wrap %0d want %0d,0,0", tu_c, tv_c, oob_c, tu_w, rcv);
                else n_pass++;
                rcv++;
            end
            if (s_valid && s_ready_c) sent++;
            stall_prev = m_valid_c && !m_ready;
            prev = '{tu_c, tv_c, oob_c};
        end
        @(negedge aclk);
        s_valid = 1'b0; m_ready = 1'b1;
        n_checks++; if (rcv !== 8) $display("FAIL bp_count got %0d want 8", rcv); else n_pass++;
    endtask

    task automatic test_config_gating();
        res_t q[$];
        res_t e;
        int   infl, n;
        bit   seen;
        load_cfg(MAT_ONE, 0, 0, MAT_ONE, 0, 0, 0, 0);
        m_ready = 1'b1;
        infl = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge aclk);
            s_valid = 1'b1; px = 12'(i); py = 12'(i);
            #1;
            if (s_ready_c) begin q.push_back(model(i, i, 1'b0)); infl++; end
        end
        @(negedge aclk);
        cfg_wen = 1'b1;
        qm = {16'd512, 16'd0, 16'd0, 16'd512};
        px = 12'd3; py = 12'd3;
        seen = 1'b0;
        for (n = 0; n < 30 && !seen; n++) begin
            if (n > 0) @(negedge aclk);
            #1;
            n_checks++; if (s_ready_c !== 1'b0) $display("FAIL gate_s_ready got %0b want 0", s_ready_c); else n_pass++;
            n_checks++; if (cfg_ready_c !== (infl == 0)) $display("FAIL gate_cfg_ready got %0b want %0b", cfg_ready_c, infl == 0); else n_pass++;
            if (m_valid_c && m_ready) begin
                e = (q.size() > 0) ? q.pop_front() : res_t'('1);
                n_checks++; if ({tu_c, tv_c, oob_c} !== e) $display("FAIL gate_old_cfg got %0d,%0d want %0d,%0d", tu_c, tv_c, e.tu, e.tv); else n_pass++;
                infl--;
            end
            seen = cfg_ready_c;
        end
        @(negedge aclk);
        cfg_wen = 1'b0;
        ca = 512; cd = 512;
        #1;
        n_checks++; if (s_ready_c !== 1'b1) $display("FAIL gate_resume got %0b want 1", s_ready_c); else n_pass++;
        e = model(3, 3, 1'b0);
        @(negedge aclk);
        s_valid = 1'b0;
        n = 1;
        while (!m_valid_c && n < 20) begin @(negedge aclk); n++; end
        n_checks++; if ({m_valid_c, tu_c, tv_c, oob_c} !== {1'b1, e}) $display("FAIL gate_new_cfg got %0b,%0d,%0d want 1,%0d,%0d", m_valid_c, tu_c, tv_c, e.tu, e.tv); else n_pass++;
        @(negedge aclk);
    endtask

    task automatic test_random();
        res_t qc[$], qw[$];
        res_t e;
        int   sent, rcv, lim;
        for (int r = 0; r < 3; r++) begin
            lim = (r == 2) ? 32768 : 512;
            load_cfg(int'($urandom_range(0, 2 * lim - 1)) - lim, int'($urandom_range(0, 2 * lim - 1)) - lim,
                     int'($urandom_range(0, 2 * lim - 1)) - lim, int'($urandom_range(0, 2 * lim - 1)) - lim,
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            sent = 0; rcv = 0;
            for (int cyc = 0; cyc < 1000 && rcv < 40; cyc++) begin
                @(negedge aclk);
                if (sent < 40) begin
                    s_valid = ($urandom_range(0, 3) != 0);
                    px = 12'($urandom); py = 12'($urandom);
                end else begin
                    s_valid = 1'b0;
                end
                m_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (m_valid_c && m_ready) begin
                    e = (qc.size() > 0) ? qc.pop_front() : res_t'('1);
                    n_checks++; if ({tu_c, tv_c, oob_c} !== e) $display("FAIL rand_clamp got %0d,%0d,%0b want %0d,%0d,%0b", tu_c, tv_c, oob_c, e.tu, e.tv, e.oob); else n_pass++;
                    e = (qw.size() > 0) ? qw.pop_front() : res_t'('1);
                    n_checks++; if ({m_valid_w, tu_w, tv_w, oob_w} !== {1'b1, e}) $display("FAIL rand_wrap got %0b,%0d,%0d,%0b want 1,%0d,%0d,%0b", m_valid_w, tu_w, tv_w, oob_w, e.tu, e.tv, e.oob); else n_pass++;
                    rcv++;
                end
                if (s_valid && s_ready_c) begin
                    qc.push_back(model(int'(px), int'(py), 1'b0));
                    qw.push_back(model(int'(px), int'(py), 1'b1));
                    sent++;
                end
            end
            n_checks++; if (rcv !== 40) $display("FAIL rand_count got %0d want 40", rcv); else n_pass++;
            @(negedge aclk);
            s_valid = 1'b0; m_ready = 1'b1;
        end
    endtask

    task automatic test_reset_midburst();
        bit any_valid;
        load_cfg(MAT_ONE, 0, 0, MAT_ONE, 0, 0, 0, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            s_valid = 1'b1; px = 12'(100 + i); py = 12'd7;
        end
        @(negedge aclk);
        s_valid = 1'b0;
        n_checks++; if ({m_valid_c, tu_c} !== {1'b1, 12'd100}) $display("FAIL rst_pre got %0b,%0d want 1,100", m_valid_c, tu_c); else n_pass++;
        #2 aresetn = 1'b0;
        #1;
        n_checks++; if ({m_valid_c, tu_c, tv_c, oob_c} !== 26'd0) $display("FAIL rst_async got %0b,%0d,%0d,%0b want 0,0,0,0", m_valid_c, tu_c, tv_c, oob_c); else n_pass++;
        n_checks++; if ({m_valid_w, tu_w, tv_w} !== 25'd0) $display("FAIL rst_async_wrap got %0b,%0d,%0d want 0,0,0", m_valid_w, tu_w, tv_w); else n_pass++;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            if (m_valid_c || m_valid_w) any_valid = 1'b1;
        end
        n_checks++; if (any_valid !== 1'b0) $display("FAIL rst_stale got valid=%0b want 0", any_valid); else n_pass++;
        n_checks++; if ({cfg_ready_c, tu_c, tv_c} !== {1'b1, 24'd0}) $display("FAIL rst_after got %0b,%0d,%0d want 1,0,0", cfg_ready_c, tu_c, tv_c); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_rotation();
        test_range();
        test_backpressure();
        test_config_gating();
        test_random();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
